// File: rtl/l2_cache_pkg.sv
// Shared types and defaults for the L2 request arbiter slice.
// Default parameter values, FSM state encoding and a modular increment helper.
package l2_cache_pkg;

  localparam int unsigned DEF_DATA_WIDTH     = 8;
  localparam int unsigned DEF_ADDR_WIDTH     = 4;
  localparam int unsigned DEF_BLOCK_SIZE     = 4;
  localparam int unsigned DEF_NUM_REQ        = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 64;
  localparam int unsigned GRANT_W            = $clog2(DEF_NUM_REQ);

  typedef logic [DEF_BLOCK_SIZE-1:0][DEF_DATA_WIDTH-1:0] block_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } arb_state_t;

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/l2_req_arbiter_if.sv
// L1-side port of the L2 cache: the arbiter is master, the L2 is slave.
interface l2_req_arbiter_if
  import l2_cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE
);

    logic [ADDR_WIDTH-1:0]                 l2_addr;
    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l2_wdata;
    logic                                  l2_read;
    logic                                  l2_write;
    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l2_rdata;
    logic                                  l2_ready;
    logic                                  l2_hit;
    logic                                  l2_valid;

    modport master (
        output l2_addr, l2_wdata, l2_read, l2_write,
        input  l2_rdata, l2_ready, l2_hit, l2_valid
    );

    modport slave (
        input  l2_addr, l2_wdata, l2_read, l2_write,
        output l2_rdata, l2_ready, l2_hit, l2_valid
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first active index at or above rr_ptr_i,
// wrapping from NUM_REQ-1 back to 0.
module rr_picker
  import l2_cache_pkg::*;
#(
    parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned SEL_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] active_i,
    input  logic [SEL_W-1:0]   rr_ptr_i,
    output logic [SEL_W-1:0]   grant_o,
    output logic               any_active_o
);

    logic [SEL_W:0]   sum;
    logic [SEL_W-1:0] idx;

    always_comb begin
        grant_o      = '0;
        any_active_o = 1'b0;
        sum          = '0;
        idx          = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_i} + (SEL_W + 1)'(k);
            if (sum >= (SEL_W + 1)'(NUM_REQ)) begin
                sum = sum - (SEL_W + 1)'(NUM_REQ);
            end
            idx = sum[SEL_W-1:0];
            if (!any_active_o && active_i[idx]) begin
                any_active_o = 1'b1;
                grant_o      = idx;
            end
        end
    end

endmodule

// File: rtl/l2_req_arbiter.sv
// Round-robin arbiter sharing the L2 L1-side port between NUM_REQ requesters.
// Optional watchdog on the L2 response enabled by defining L2_ARB_TIMEOUT_EN.
module l2_req_arbiter
  import l2_cache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned BLOCK_SIZE     = DEF_BLOCK_SIZE,
    parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]                 req_addr,
    input  logic [NUM_REQ-1:0][BLOCK_SIZE-1:0][DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]                                 req_read,
    input  logic [NUM_REQ-1:0]                                 req_write,
    output logic [NUM_REQ-1:0]                                 req_ready,
    output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]              req_rdata,
    output logic                                               req_hit,
    output logic                                               req_valid,
    output logic                                               req_error,
    output logic [$clog2(NUM_REQ)-1:0]                         grant_id,
    output logic                                               busy,
    l2_req_arbiter_if.master                                   l2
);

    localparam int unsigned SEL_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("l2_req_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t                            state_q;
    logic [SEL_W-1:0]                      rr_ptr_q;
    logic [SEL_W-1:0]                      grant_q;
    logic                                  busy_q;
    logic [ADDR_WIDTH-1:0]                 l2_addr_q;
    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l2_wdata_q;
    logic                                  l2_read_q;
    logic                                  l2_write_q;
    logic [NUM_REQ-1:0]                    req_ready_q;
    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] req_rdata_q;
    logic                                  req_hit_q;
    logic                                  req_valid_q;

    logic [NUM_REQ-1:0] active;
    logic [SEL_W-1:0]   pick;
    logic               any_active;
    logic [SEL_W-1:0]   rr_next;

    assign active  = req_read | req_write;
    assign rr_next = SEL_W'(wrap_inc(32'(grant_q), NUM_REQ));

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .active_i     (active),
        .rr_ptr_i     (rr_ptr_q),
        .grant_o      (pick),
        .any_active_o (any_active)
    );

`ifdef L2_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             req_error_q;
    logic             tmo_expired;

    // Counter holds the number of completed ISSUE cycles; the edge ending
    // cycle TIMEOUT_CYCLES is the one that aborts.
    assign tmo_expired = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign req_error   = req_error_q;
`else
    assign req_error   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            l2_addr_q   <= '0;
            l2_wdata_q  <= '0;
            l2_read_q   <= 1'b0;
            l2_write_q  <= 1'b0;
            req_ready_q <= '0;
            req_rdata_q <= '0;
            req_hit_q   <= 1'b0;
            req_valid_q <= 1'b0;
`ifdef L2_ARB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            req_error_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_active) begin
                        grant_q    <= pick;
                        l2_addr_q  <= req_addr[pick];
                        l2_wdata_q <= req_wdata[pick];
                        // Read wins when both strobes are raised together.
                        l2_read_q  <= req_read[pick];
                        l2_write_q <= req_write[pick] & ~req_read[pick];
                        busy_q     <= 1'b1;
                        state_q    <= ISSUE;
`ifdef L2_ARB_TIMEOUT_EN
                        tmo_cnt_q  <= '0;
`endif
                    end
                end
                ISSUE: begin
                    if (l2.l2_ready) begin
                        req_rdata_q <= l2.l2_rdata;
                        req_hit_q   <= l2.l2_hit;
                        req_valid_q <= l2.l2_valid;
                        req_ready_q <= NUM_REQ'(1) << grant_q;
                        l2_read_q   <= 1'b0;
                        l2_write_q  <= 1'b0;
                        rr_ptr_q    <= rr_next;
                        state_q     <= DONE;
                    end
`ifdef L2_ARB_TIMEOUT_EN
                    else if (tmo_expired) begin
                        req_rdata_q <= '0;
                        req_hit_q   <= 1'b0;
                        req_valid_q <= 1'b0;
                        req_error_q <= 1'b1;
                        req_ready_q <= NUM_REQ'(1) << grant_q;
                        l2_read_q   <= 1'b0;
                        l2_write_q  <= 1'b0;
                        rr_ptr_q    <= rr_next;
                        state_q     <= DONE;
                    end else begin
                        tmo_cnt_q   <= tmo_cnt_q + CNT_W'(1);
                    end
`endif
                end
                DONE: begin
                    req_ready_q <= '0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
`ifdef L2_ARB_TIMEOUT_EN
                    req_error_q <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign req_rdata   = req_rdata_q;
    assign req_hit     = req_hit_q;
    assign req_valid   = req_valid_q;
    assign grant_id    = grant_q;
    assign busy        = busy_q;
    assign l2.l2_addr  = l2_addr_q;
    assign l2.l2_wdata = l2_wdata_q;
    assign l2.l2_read  = l2_read_q;
    assign l2.l2_write = l2_write_q;

endmodule
